// File: rtl/spi_cmd_sched_if.sv
// Bundles the SPI-slave byte handshake, requester bus and scheduler status
// into one interface. The scheduler takes the slave modport; whoever drives
// the SPI slave and the requesters takes the master modport.
interface spi_cmd_sched_if #(
    parameter int N_REQ = 4
);
    logic                 i_RX_DV;
    logic [7:0]           i_RX_Byte;
    logic                 i_CS_n;
    logic [N_REQ-1:0]     i_Req;
    logic [8*N_REQ-1:0]   i_Req_Data;
    logic [N_REQ-1:0]     o_Grant;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 o_Fsm_Signal;
    logic                 o_Fsm_Strobe;
    logic                 o_Err;
    logic                 o_Busy;

    modport slave (
        input  i_RX_DV, i_RX_Byte, i_CS_n, i_Req, i_Req_Data,
        output o_Grant, o_TX_DV, o_TX_Byte, o_Fsm_Signal, o_Fsm_Strobe, o_Err, o_Busy
    );

    modport master (
        output i_RX_DV, i_RX_Byte, i_CS_n, i_Req, i_Req_Data,
        input  o_Grant, o_TX_DV, o_TX_Byte, o_Fsm_Signal, o_Fsm_Strobe, o_Err, o_Busy
    );
endinterface

// File: rtl/spi_cmd_sched.sv
// SPI command scheduler: decodes bytes received by an SPI slave, loads the
// next MISO byte (requester data, status or error marker), drives a single
// FSM input bit, and grants requesters once their byte has been shifted out.
module spi_cmd_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    spi_cmd_sched_if.slave   bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DECODE, LOAD, WAIT_SHIFT} state_t;

    state_t            state;
    logic [7:0]        cmd;
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic              pend;
    logic [PW-1:0]     pend_idx;
    logic              cs_prev;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              fsm_sig;
    logic              fsm_stb;
    logic              err;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [N_REQ-1:0]  grant;
    logic [2:0]        k;

    // Round-robin search starting at the pointer; returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] req, input logic [PW-1:0] start);
        logic          found;
        logic [PW-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(start) + i) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
        return {found, win};
    endfunction

    // Requests folded into four bits; requesters 3 and above share bit 3.
    function automatic logic [3:0] status_nib(input logic [N_REQ-1:0] req);
        logic [3:0] nib;
        nib = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i < 3) nib[i] = nib[i] | req[i];
            else       nib[3] = nib[3] | req[i];
        end
        return nib;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input int idx);
        return PW'((idx + 1) % N_REQ);
    endfunction

    assign k = cmd[2:0];

    // Poll winner for the current pointer and request vector.
    always_comb begin
        {pick_found, pick_idx} = rr_pick(bus.i_Req, ptr);
    end

    // Grant fires in the same cycle the master clocks in the next byte.
    always_comb begin
        grant = '0;
        if (state == WAIT_SHIFT && bus.i_RX_DV && !bus.i_CS_n && pend)
            grant[pend_idx] = 1'b1;
    end

    // Command FSM with registered TX/FSM/error outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= IDLE;
            cmd      <= '0;
            ptr      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
            cs_prev  <= 1'b1;
            tx_dv    <= 1'b0;
            tx_byte  <= '0;
            fsm_sig  <= 1'b0;
            fsm_stb  <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_dv   <= 1'b0;
            fsm_stb <= 1'b0;
            cs_prev <= bus.i_CS_n;
            case (state)
                IDLE: begin
                    if (bus.i_RX_DV) begin
                        cmd   <= bus.i_RX_Byte;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= LOAD;
                    pend  <= 1'b0;
                    if (cmd[7:1] == 7'd0) begin
                        fsm_sig <= cmd[0];
                        fsm_stb <= 1'b1;
                    end else if (cmd == 8'hFF) begin
                        tx_dv    <= 1'b1;
                        tx_byte  <= pick_found ? bus.i_Req_Data[8*int'(pick_idx) +: 8] : 8'h00;
                        pend     <= pick_found;
                        pend_idx <= pick_idx;
                    end else if (cmd == 8'hFE) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= {err, 3'b000, status_nib(bus.i_Req)};
                        err     <= 1'b0;
                    end else if (cmd[7:3] == 5'b11000 && int'(k) < N_REQ) begin
                        tx_dv    <= 1'b1;
                        tx_byte  <= bus.i_Req_Data[8*int'(k) +: 8];
                        pend     <= bus.i_Req[k];
                        pend_idx <= PW'(k);
                        ptr      <= next_ptr(int'(k));
                    end else begin
                        tx_dv   <= 1'b1;
                        tx_byte <= 8'hEE;
                        err     <= 1'b1;
                    end
                    // A byte arriving mid-command is lost; flag it even over a status clear.
                    if (bus.i_RX_DV) err <= 1'b1;
                end
                LOAD: begin
                    if (bus.i_RX_DV) err <= 1'b1;
                    cnt   <= '0;
                    state <= (cmd[7:1] == 7'd0) ? IDLE : WAIT_SHIFT;
                end
                WAIT_SHIFT: begin
                    if (bus.i_RX_DV) begin
                        if (!bus.i_CS_n && pend) ptr <= next_ptr(int'(pend_idx));
                        pend  <= 1'b0;
                        cmd   <= bus.i_RX_Byte;
                        state <= DECODE;
                    end else if (bus.i_CS_n && !cs_prev) begin
                        pend  <= 1'b0;
                        state <= IDLE;
                    end else if (!bus.i_CS_n) begin
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            pend  <= 1'b0;
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Grant      = grant;
    assign bus.o_TX_DV      = tx_dv;
    assign bus.o_TX_Byte    = tx_byte;
    assign bus.o_Fsm_Signal = fsm_sig;
    assign bus.o_Fsm_Strobe = fsm_stb;
    assign bus.o_Err        = err;
    assign bus.o_Busy       = (state != IDLE);
endmodule

// File: tb/tb_spi_cmd_sched.sv
// Bench for spi_cmd_sched: directed scenarios followed by random command
// streams, each checked against a transaction-level model of the scheduler.
module tb_spi_cmd_sched;
    localparam int NR = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mism = 0;

    spi_cmd_sched_if #(.N_REQ(NR)) bus ();

    spi_cmd_sched #(.N_REQ(NR), .TIMEOUT(TO)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Model state: pointer, sticky error, pending grant (-1 none), waiting flag.
    int         m_ptr;
    bit         m_err;
    int         m_pend;
    bit         m_wait;
    logic [7:0] m_tx;
    bit         m_fsm;
    logic [3:0] req;
    logic [7:0] dat [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_err = 0; m_pend = -1; m_wait = 0; m_tx = 8'h00; m_fsm = 0;
    endtask

    task automatic set_req(input logic [3:0] r);
        req = r;
        bus.i_Req = r;
        for (int i = 0; i < NR; i++) bus.i_Req_Data[8*i +: 8] = dat[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dv"},    32'(bus.o_TX_DV), 0);
        chk({tag, "_byte"},  32'(bus.o_TX_Byte), 0);
        chk({tag, "_grant"}, 32'(bus.o_Grant), 0);
        chk({tag, "_fsm"},   32'(bus.o_Fsm_Signal), 0);
        chk({tag, "_stb"},   32'(bus.o_Fsm_Strobe), 0);
        chk({tag, "_err"},   32'(bus.o_Err), 0);
        chk({tag, "_busy"},  32'(bus.o_Busy), 0);
    endtask

    // Send one command byte with CS low and check the whole command response.
    task automatic run_cmd(input logic [7:0] c, input bit drop_extra);
        logic [3:0] exp_g;
        bit         is_tx;
        exp_g = '0;
        if (m_wait && m_pend >= 0) begin
            exp_g = 4'(1 << m_pend);
            m_ptr = (m_pend + 1) % NR;
        end
        m_pend = -1;
        m_wait = 0;
        @(negedge clk);
        bus.i_RX_DV = 1'b1; bus.i_RX_Byte = c;
        #1 chk("grant", 32'(bus.o_Grant), 32'(exp_g));
        @(negedge clk);
        bus.i_RX_DV = drop_extra; bus.i_RX_Byte = 8'h5A;
        chk("dv_decode", 32'(bus.o_TX_DV), 0);
        is_tx = 1;
        if (c <= 8'h01) begin
            m_fsm = c[0]; is_tx = 0;
        end else if (c == 8'hFF) begin
            m_tx = 8'h00;
            for (int i = 0; i < NR; i++) begin
                int j;
                j = (m_ptr + i) % NR;
                if (req[j]) begin m_tx = dat[j]; m_pend = j; break; end
            end
        end else if (c >= 8'hC0 && c < 8'hC0 + NR) begin
            int kk;
            kk = int'(c) - 'hC0;
            m_tx = dat[kk];
            m_pend = req[kk] ? kk : -1;
            m_ptr = (kk + 1) % NR;
        end else if (c == 8'hFE) begin
            m_tx = {m_err, 3'b000, req};
            m_err = 0;
        end else begin
            m_tx = 8'hEE; m_err = 1;
        end
        if (drop_extra) m_err = 1;
        @(negedge clk);
        bus.i_RX_DV = 1'b0;
        chk("tx_dv",  32'(bus.o_TX_DV), 32'(is_tx));
        chk("strobe", 32'(bus.o_Fsm_Strobe), 32'(!is_tx));
        chk("tx_byte", 32'(bus.o_TX_Byte), 32'(m_tx));
        chk("fsm_sig", 32'(bus.o_Fsm_Signal), 32'(m_fsm));
        chk("err", 32'(bus.o_Err), 32'(m_err));
        chk("busy_load", 32'(bus.o_Busy), 1);
        m_wait = is_tx;
        @(negedge clk);
        chk("busy_after", 32'(bus.o_Busy), 32'(is_tx));
        chk("tx_dv_off", 32'(bus.o_TX_DV), 0);
        chk("strobe_off", 32'(bus.o_Fsm_Strobe), 0);
    endtask

    task automatic cs_abort();
        @(negedge clk);
        bus.i_CS_n = 1'b1;
        @(negedge clk);
        bus.i_CS_n = 1'b0;
        m_wait = 0; m_pend = -1;
        chk("abort_busy", 32'(bus.o_Busy), 0);
        chk("abort_byte", 32'(bus.o_TX_Byte), 32'(m_tx));
        chk("abort_grant", 32'(bus.o_Grant), 0);
    endtask

    task automatic wait_timeout();
        repeat (TO - 2) @(negedge clk);
        chk("to_early_busy", 32'(bus.o_Busy), 32'(m_wait));
        repeat (5) @(negedge clk);
        if (m_wait) m_err = 1;
        m_wait = 0; m_pend = -1;
        chk("to_busy", 32'(bus.o_Busy), 0);
        chk("to_err", 32'(bus.o_Err), 32'(m_err));
        chk("to_byte", 32'(bus.o_TX_Byte), 32'(m_tx));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.i_RX_DV = 1'b0; bus.i_RX_Byte = '0; bus.i_CS_n = 1'b1;
        for (int i = 0; i < NR; i++) dat[i] = 8'(8'h10 + i);
        set_req(4'b1010);
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        bus.i_CS_n = 1'b0;

        // Round-robin polling with wrap, then FSM commands.
        run_cmd(8'hFF, 0);
        chk("rr_first", 32'(bus.o_TX_Byte), 32'h11);
        run_cmd(8'hFF, 0);
        chk("rr_second", 32'(bus.o_TX_Byte), 32'h13);
        run_cmd(8'hFF, 0);
        chk("rr_wrap", 32'(bus.o_TX_Byte), 32'h11);
        run_cmd(8'h01, 0);
        run_cmd(8'h00, 0);

        // Empty poll, invalid command, status read clearing the error.
        set_req(4'b0000);
        run_cmd(8'hFF, 0);
        run_cmd(8'h55, 0);
        set_req(4'b0101);
        run_cmd(8'hFE, 0);
        chk("status_byte", 32'(bus.o_TX_Byte), 32'h85);
        run_cmd(8'hC5, 0);
        run_cmd(8'hFE, 0);

        // Abort by CS rising keeps the pointer: the same requester reloads.
        set_req(4'b0100);
        run_cmd(8'hFF, 0);
        cs_abort();
        run_cmd(8'hFF, 0);
        chk("reload_req2", 32'(bus.o_TX_Byte), 32'h12);

        // Timeout, reset mid-wait, byte dropped during decode.
        run_cmd(8'hFF, 0);
        wait_timeout();
        set_req(4'b0011);
        run_cmd(8'hC1, 0);
        pulse_reset();
        run_cmd(8'hFF, 1);
        run_cmd(8'hFE, 0);

        // Random command streams.
        for (int it = 0; it < 200; it++) begin
            logic [7:0] c;
            int sel, act;
            for (int i = 0; i < NR; i++) dat[i] = 8'($urandom);
            set_req(4'($urandom));
            sel = $urandom_range(0, 7);
            case (sel)
                0: c = 8'h00;
                1: c = 8'h01;
                2, 3: c = 8'hFF;
                4: c = 8'hFE;
                5: c = 8'(8'hC0 + $urandom_range(0, 5));
                default: c = 8'($urandom);
            endcase
            run_cmd(c, ($urandom_range(0, 15) == 0));
            act = $urandom_range(0, 19);
            if (act < 4) repeat ($urandom_range(1, 4)) @(negedge clk);
            else if (act < 7) cs_abort();
            else if (act == 7) wait_timeout();
            else if (act == 8) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/spi_cmd_sched.md
SPI_CMD_SCHED -- requirements
Module: spi_cmd_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of TX-data requesters (1..8).
REQ-002 Parameter TIMEOUT, default 255, max cycles a loaded byte may wait for consumption with CS low.
REQ-003 i_Clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-004 i_Rst  in  1  reset, asynchronous, active-high.
REQ-005 i_RX_DV  in  1  one-cycle pulse: SPI slave received a byte.
REQ-006 i_RX_Byte  in  8  received command byte, valid with i_RX_DV.
REQ-007 i_CS_n  in  1  SPI chip select, active-low, synchronous to i_Clk.
REQ-008 i_Req  in  N_REQ  per-requester TX-data request, level.
REQ-009 i_Req_Data  in  8*N_REQ  requester k byte at bits [8k+7:8k].
REQ-010 o_Grant  out  N_REQ  one-hot one-cycle pulse: requester's byte shifted to master.
REQ-011 o_TX_DV  out  1  one-cycle pulse loading o_TX_Byte into SPI slave.
REQ-012 o_TX_Byte  out  8  byte for next MISO transfer, held until next load.
REQ-013 o_Fsm_Signal  out  1  FSM input bit, held.
REQ-014 o_Fsm_Strobe  out  1  one-cycle pulse: o_Fsm_Signal updated.
REQ-015 o_Err  out  1  sticky error flag.
REQ-016 o_Busy  out  1  high in any state except IDLE.

Function
REQ-017 States SHALL be IDLE, DECODE, LOAD, WAIT_SHIFT.
REQ-018 IDLE or WAIT_SHIFT + i_RX_DV at cycle t: latch byte, enter DECODE at t+1; o_TX_DV / o_Fsm_Strobe / o_Err update at t+2 (LOAD).
REQ-019 Cmd 0x00/0x01: o_Fsm_Signal <= byte[0], o_Fsm_Strobe pulse at t+2, no TX load, return to IDLE.
REQ-020 Cmd 0xFF (poll): round-robin search of i_Req from pointer; winner's byte loaded; none pending -> load 0x00, no grant pending.
REQ-021 Cmd 0xC0+k, k<N_REQ: load requester k byte regardless of i_Req; grant pending only if i_Req[k]=1 at DECODE.
REQ-022 Cmd 0xFE (status): load {o_Err, 3'b000, i_Req zero-extended to 4 bits, upper requesters ORed into bit 3 when N_REQ>4}.
REQ-023 Any other cmd (incl. 0xC0+k, k>=N_REQ): load 0xEE, set o_Err.
REQ-024 After any TX load enter WAIT_SHIFT; wait counter cleared.
REQ-025 WAIT_SHIFT + i_RX_DV with i_CS_n=0: byte consumed; pending grant pulses o_Grant same cycle; new byte decoded as command per REQ-018.
REQ-026 RR pointer advances to (winner+1) mod N_REQ only on o_Grant; direct reads (0xC0+k) also advance it to k+1.
REQ-027 WAIT_SHIFT + i_CS_n rising (0->1) before consumption: abort, no grant, pointer unchanged, IDLE; o_TX_Byte held.
REQ-028 WAIT_SHIFT with i_CS_n=0 and counter reaching TIMEOUT: abort as REQ-027 and set o_Err.
REQ-029 i_RX_DV while in DECODE or LOAD: byte dropped, o_Err set, current command completes.
REQ-030 o_Err cleared only by reset or by cmd 0xFE after its status byte is loaded (status reports pre-clear value).
REQ-031 Requester drop between DECODE and consumption: grant still issued; requesters SHALL hold i_Req until o_Grant.
REQ-032 At most one o_Grant bit and one o_TX_DV pulse per command.

Reset
REQ-033 i_Rst high: state IDLE, o_TX_DV=0, o_TX_Byte=0x00, o_Grant=0, o_Fsm_Signal=0, o_Fsm_Strobe=0, o_Err=0, o_Busy=0, pointer=0, counter=0, grant-pending cleared.
REQ-034 Reset mid-WAIT_SHIFT: pending grant discarded; no o_Grant after release.

Verification
REQ-035 i_Req=4'b1010, data k=0x10+k, CS low, cmd 0xFF -> o_TX_DV at t+2 with 0x11; next RX_DV -> o_Grant=4'b0010; repeat 0xFF -> 0x13, then 0x11 (wrap).
REQ-036 Cmd 0x01 then 0x00 -> o_Fsm_Signal 1 then 0, one o_Fsm_Strobe each, no o_TX_DV.
REQ-037 Cmd 0xFF with i_Req=0 -> TX 0x00, no grant on next RX_DV; cmd 0x55 -> TX 0xEE, o_Err=1; cmd 0xFE -> TX 0x80|i_Req, then o_Err=0.
REQ-038 Cmd 0xFF loads requester 2, CS_n rises before next byte -> no grant, pointer unchanged; next 0xFF reloads requester 2.
REQ-039 Loaded byte, CS held low, no RX_DV for TIMEOUT cycles -> IDLE, o_Err=1, no grant; i_Rst pulse mid-WAIT_SHIFT -> all outputs reset values.
